// File: rtl/ppm_pkg.sv
// ---------------------------------------------------------------------------
// ppm_pkg
//   Shared definitions for the PPM decoder frame controller.
//   - state_t : frame controller FSM encoding (IDLE / RECV / ERR).
//               The fourth code, 2'd3, is never entered; the FSM sends it
//               back to IDLE.
//   - len_w() : width needed to hold a frame length of 0..max_len.
//   - to_w()  : width of the inter-byte timeout counter.
// ---------------------------------------------------------------------------
package ppm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    ERR  = 2'd2
  } state_t;

  // A frame length counter must represent max_len itself, hence the +1.
  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // The timer only ever counts up to timeout-1, so $clog2(timeout) bits
  // are enough; clamp to one bit so tiny timeouts still give a legal vector.
  function automatic int to_w(input int timeout);
    return (timeout < 3) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/ppm_timeout_cnt.sv
// ---------------------------------------------------------------------------
// ppm_timeout_cnt
//   Inter-byte timeout counter for the frame controller.
//   Ports:
//     clk16   in   sampling clock, posedge
//     rst_n   in   asynchronous active-low reset
//     clear   in   forces the count back to zero (has priority)
//     enable  in   one idle cycle inside a frame: count up
//     expire  out  combinational pulse; high in the idle cycle whose
//                  increment would bring the count to TIMEOUT-1
//   The count returns to zero on expiry so it is already idle when the
//   controller leaves RECV.
// ---------------------------------------------------------------------------
module ppm_timeout_cnt
  import ppm_pkg::*;
#(
  parameter int TIMEOUT = 255,
  localparam int TO_W   = to_w(TIMEOUT)
) (
  input  logic clk16,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  logic [TO_W-1:0] count;

  // Expiry is flagged one increment early so that the controller's state
  // change lands on the same edge at which the count would reach TIMEOUT-1.
  assign expire = enable && (count == TO_W'(TIMEOUT - 2));

  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TO_W'(1);
    end
  end

endmodule

// File: rtl/ppm_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ppm_frame_ctrl
//   Frame controller for the PPM decoder datapath. Tracks SOF/EOF framing,
//   forwards decoded words to the byte sink through a registered output with
//   a one-cycle valid pulse, counts frame length and flags overflow and
//   inter-byte timeout. Sits between the symbol/byte assembler and the sink.
//   Ports:
//     clk16         in   sampling clock, all logic on posedge
//     rst_n         in   asynchronous active-low reset
//     sof_rcv_in    in   1-cycle start-of-frame pulse
//     eof_rcv_in    in   1-cycle end-of-frame pulse
//     onebyte_in    in   1-cycle strobe, dout_data valid this cycle
//     dout_data     in   decoded word from the assembler
//     Dout          out  registered accepted word
//     dout_valid    out  1-cycle pulse, Dout updated this cycle
//     state         out  FSM state (IDLE=0, RECV=1, ERR=2)
//     frame_len     out  words accepted in the current / last frame
//     frame_done    out  1-cycle pulse after a clean EOF
//     err_overflow  out  sticky, cleared by the next SOF
//     err_timeout   out  sticky, cleared by the next SOF
//   A strobe at cycle N appears on Dout/dout_valid at N+1; no backpressure.
// ---------------------------------------------------------------------------
module ppm_frame_ctrl
  import ppm_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 64,
  parameter int TIMEOUT = 255,
  localparam int LEN_W  = len_w(MAX_LEN)
) (
  input  logic              clk16,
  input  logic              rst_n,
  input  logic              sof_rcv_in,
  input  logic              eof_rcv_in,
  input  logic              onebyte_in,
  input  logic [DATA_W-1:0] dout_data,
  output logic [DATA_W-1:0] Dout,
  output logic              dout_valid,
  output logic [1:0]        state,
  output logic [LEN_W-1:0]  frame_len,
  output logic              frame_done,
  output logic              err_overflow,
  output logic              err_timeout
);

  state_t cur_state;
  state_t nstate;

  logic len_full;
  logic timer_clear;
  logic timer_enable;
  logic timer_expire;

  assign state    = cur_state;
  assign len_full = (frame_len == LEN_W'(MAX_LEN));

  // The timer only runs on genuinely idle RECV cycles; any framing event or
  // strobe, or being outside RECV, holds it at zero.
  assign timer_clear  = (cur_state != RECV) || eof_rcv_in || sof_rcv_in || onebyte_in;
  assign timer_enable = !timer_clear;

  ppm_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk16  (clk16),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  // Next-state logic. Inside RECV the events are resolved in strict
  // priority: EOF, then SOF restart, then strobe (overflow or accept), then
  // the idle timeout.
  always_comb begin
    nstate = cur_state;
    case (cur_state)
      IDLE: begin
        if (sof_rcv_in) nstate = RECV;
      end
      RECV: begin
        if (eof_rcv_in) begin
          nstate = IDLE;
        end else if (sof_rcv_in) begin
          nstate = RECV;
        end else if (onebyte_in) begin
          nstate = len_full ? ERR : RECV;
        end else if (timer_expire) begin
          nstate = ERR;
        end
      end
      ERR: begin
        if (sof_rcv_in) nstate = RECV;
      end
      default: nstate = IDLE;
    endcase
  end

  // State register and registered output stage. dout_valid and frame_done
  // are single-cycle pulses, so they default low every cycle.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      cur_state    <= IDLE;
      Dout         <= '0;
      dout_valid   <= 1'b0;
      frame_len    <= '0;
      frame_done   <= 1'b0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      cur_state  <= nstate;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
      case (cur_state)
        IDLE, ERR: begin
          if (sof_rcv_in) begin
            Dout         <= '0;
            frame_len    <= '0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
          end
        end
        RECV: begin
          if (eof_rcv_in) begin
            // A word arriving with EOF still belongs to this frame. If the
            // frame is already full that word is lost and the end is not
            // reported as clean.
            if (onebyte_in && len_full) begin
              err_overflow <= 1'b1;
            end else begin
              frame_done <= 1'b1;
              if (onebyte_in) begin
                Dout       <= dout_data;
                dout_valid <= 1'b1;
                frame_len  <= frame_len + LEN_W'(1);
              end
            end
          end else if (sof_rcv_in) begin
            frame_len <= '0;
          end else if (onebyte_in) begin
            if (len_full) begin
              err_overflow <= 1'b1;
            end else begin
              Dout       <= dout_data;
              dout_valid <= 1'b1;
              frame_len  <= frame_len + LEN_W'(1);
            end
          end else if (timer_expire) begin
            err_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppm_frame_ctrl.sv
module tb_ppm_frame_ctrl;

  localparam int DATA_W  = 8;
  localparam int MAX_LEN = 4;
  localparam int TIMEOUT = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic              clk16 = 1'b0;
  logic              rst_n = 1'b0;
  logic              sof_rcv_in = 1'b0;
  logic              eof_rcv_in = 1'b0;
  logic              onebyte_in = 1'b0;
  logic [DATA_W-1:0] dout_data = '0;
  logic [DATA_W-1:0] Dout;
  logic              dout_valid;
  logic [1:0]        state;
  logic [LEN_W-1:0]  frame_len;
  logic              frame_done;
  logic              err_overflow;
  logic              err_timeout;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    bit                is_done;
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk16 = ~clk16;

  ppm_frame_ctrl #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk16        (clk16),
    .rst_n        (rst_n),
    .sof_rcv_in   (sof_rcv_in),
    .eof_rcv_in   (eof_rcv_in),
    .onebyte_in   (onebyte_in),
    .dout_data    (dout_data),
    .Dout         (Dout),
    .dout_valid   (dout_valid),
    .state        (state),
    .frame_len    (frame_len),
    .frame_done   (frame_done),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs from a negedge; returns at the following
  // negedge with inputs released and the registered response visible.
  task automatic applyStimulus(input logic sof, input logic eof, input logic ob, input logic [DATA_W-1:0] d);
    sof_rcv_in = sof;
    eof_rcv_in = eof;
    onebyte_in = ob;
    dout_data  = d;
    @(negedge clk16);
    sof_rcv_in = 1'b0;
    eof_rcv_in = 1'b0;
    onebyte_in = 1'b0;
    dout_data  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk16);
  endtask

  task automatic expectWord(input logic [DATA_W-1:0] d, input logic [LEN_W-1:0] len);
    exp_t e;
    e.is_done = 1'b0;
    e.data    = d;
    e.len     = len;
    sb.push_back(e);
  endtask

  task automatic expectDone(input logic [LEN_W-1:0] len);
    exp_t e;
    e.is_done = 1'b1;
    e.data    = '0;
    e.len     = len;
    sb.push_back(e);
  endtask

  // Monitor: every dout_valid / frame_done pulse must match the oldest
  // expected event; a word and a done in the same cycle are taken in that order.
  always @(negedge clk16) begin
    if (rst_n) begin
      if (dout_valid) begin
        if (sb.size() == 0) begin
          assertions++;
          failures++;
          $display("[TB] FAIL unexpected_word: got Dout=%0h, expected no output", Dout);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("sb_kind_word", {31'b0, mon_e.is_done}, 32'd0);
          checkOutput("sb_dout", {24'b0, Dout}, {24'b0, mon_e.data});
          checkOutput("sb_word_len", {29'b0, frame_len}, {29'b0, mon_e.len});
        end
      end
      if (frame_done) begin
        if (sb.size() == 0) begin
          assertions++;
          failures++;
          $display("[TB] FAIL unexpected_done: got frame_done=1 len=%0d, expected no output", frame_len);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("sb_kind_done", {31'b0, mon_e.is_done}, 32'd1);
          checkOutput("sb_done_len", {29'b0, frame_len}, {29'b0, mon_e.len});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    #12;
    checkOutput("rst_state", {30'b0, state}, 32'd0);
    checkOutput("rst_dout", {24'b0, Dout}, 32'd0);
    checkOutput("rst_valid", {31'b0, dout_valid}, 32'd0);
    checkOutput("rst_len", {29'b0, frame_len}, 32'd0);
    checkOutput("rst_done", {31'b0, frame_done}, 32'd0);
    checkOutput("rst_errs", {30'b0, err_overflow, err_timeout}, 32'd0);
    @(negedge clk16);
    rst_n = 1'b1;
    idle(2);

    // Basic frame: three words then EOF
    $display("[TB] basic frame");
    applyStimulus(1, 0, 0, 8'h00);
    checkOutput("t1_state_recv", {30'b0, state}, 32'd1);
    expectWord(8'hA1, 3'd1); applyStimulus(0, 0, 1, 8'hA1);
    expectWord(8'hB2, 3'd2); applyStimulus(0, 0, 1, 8'hB2);
    expectWord(8'hC3, 3'd3); applyStimulus(0, 0, 1, 8'hC3);
    expectDone(3'd3);        applyStimulus(0, 1, 0, 8'h00);
    idle(2);
    checkOutput("t1_state_idle", {30'b0, state}, 32'd0);
    checkOutput("t1_dout_hold", {24'b0, Dout}, 32'hC3);
    checkOutput("t1_len_hold", {29'b0, frame_len}, 32'd3);

    // Overflow: five strobes into a four-word frame
    $display("[TB] overflow");
    applyStimulus(1, 0, 0, 8'h00);
    expectWord(8'h11, 3'd1); applyStimulus(0, 0, 1, 8'h11);
    expectWord(8'h22, 3'd2); applyStimulus(0, 0, 1, 8'h22);
    expectWord(8'h33, 3'd3); applyStimulus(0, 0, 1, 8'h33);
    expectWord(8'h44, 3'd4); applyStimulus(0, 0, 1, 8'h44);
    applyStimulus(0, 0, 1, 8'h55);
    checkOutput("t2_state_err", {30'b0, state}, 32'd2);
    checkOutput("t2_err_overflow", {31'b0, err_overflow}, 32'd1);
    checkOutput("t2_len_sat", {29'b0, frame_len}, 32'd4);
    checkOutput("t2_dout_last", {24'b0, Dout}, 32'h44);
    applyStimulus(0, 1, 0, 8'h00);
    checkOutput("t2_eof_ignored", {30'b0, state}, 32'd2);

    // Timeout: SOF clears the error state, then silence for TIMEOUT cycles
    $display("[TB] timeout");
    applyStimulus(1, 0, 0, 8'h00);
    checkOutput("t3_sof_clears_ovf", {31'b0, err_overflow}, 32'd0);
    checkOutput("t3_sof_len", {29'b0, frame_len}, 32'd0);
    checkOutput("t3_sof_dout", {24'b0, Dout}, 32'd0);
    idle(TIMEOUT - 2);
    checkOutput("t3_before_expiry", {30'b0, state}, 32'd1);
    idle(1);
    checkOutput("t3_state_err", {30'b0, state}, 32'd2);
    checkOutput("t3_err_timeout", {31'b0, err_timeout}, 32'd1);
    applyStimulus(1, 0, 0, 8'h00);
    checkOutput("t3_sof_clears_to", {31'b0, err_timeout}, 32'd0);
    checkOutput("t3_sof_recv", {30'b0, state}, 32'd1);

    // Word on the same cycle as EOF
    $display("[TB] word with eof");
    expectWord(8'h55, 3'd1);
    expectDone(3'd1);
    applyStimulus(0, 1, 1, 8'h55);
    checkOutput("t4_state_idle", {30'b0, state}, 32'd0);
    checkOutput("t4_len", {29'b0, frame_len}, 32'd1);

    // SOF restart in the middle of a frame
    $display("[TB] restart");
    applyStimulus(1, 0, 0, 8'h00);
    expectWord(8'h01, 3'd1); applyStimulus(0, 0, 1, 8'h01);
    expectWord(8'h02, 3'd2); applyStimulus(0, 0, 1, 8'h02);
    applyStimulus(1, 0, 0, 8'h00);
    checkOutput("t5_restart_len", {29'b0, frame_len}, 32'd0);
    checkOutput("t5_restart_state", {30'b0, state}, 32'd1);
    expectWord(8'h03, 3'd1); applyStimulus(0, 0, 1, 8'h03);
    expectDone(3'd1);        applyStimulus(0, 1, 0, 8'h00);
    idle(1);
    checkOutput("t5_len_final", {29'b0, frame_len}, 32'd1);

    // Asynchronous reset mid-frame
    $display("[TB] reset mid-frame");
    applyStimulus(1, 0, 0, 8'h00);
    expectWord(8'h77, 3'd1); applyStimulus(0, 0, 1, 8'h77);
    expectWord(8'h88, 3'd2); applyStimulus(0, 0, 1, 8'h88);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_state", {30'b0, state}, 32'd0);
    checkOutput("t6_dout", {24'b0, Dout}, 32'd0);
    checkOutput("t6_len", {29'b0, frame_len}, 32'd0);
    checkOutput("t6_pulses", {30'b0, dout_valid, frame_done}, 32'd0);
    @(negedge clk16);
    #2 rst_n = 1'b1;
    idle(4);
    checkOutput("t6_still_idle", {30'b0, state}, 32'd0);

    checkOutput("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
